// File: rtl/mem_port_arbiter.sv
// Two-requester RAM port arbiter. Round-robin on ties, one RAM access in flight,
// fixed RD_LAT-cycle access window followed by a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic [31:0]   m0_rdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic [31:0]   m1_rdata,
  output logic          m1_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_cnt;
  logic          r_last;  // 1 = m1 owns / was granted last
  logic          r_en, r_we, r_rdy0, r_rdy1, r_busy;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata, r_rd0, r_rd1;
  logic          w_any, w_pick, w_last_acc;
  logic          w_en_nxt, w_rdy0_nxt, w_rdy1_nxt, w_busy_nxt;

  assign w_any      = m0_req | m1_req;
  // m1 wins when alone, or on a tie when m0 was granted last
  assign w_pick     = m1_req & (~m0_req | ~r_last);
  assign w_last_acc = (r_state == S_ACCESS) && (r_cnt == 3'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 3'd1) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_en_nxt   = (r_state == S_IDLE) && w_any;
    w_rdy0_nxt = w_last_acc && !r_last;
    w_rdy1_nxt = w_last_acc && r_last;
    w_busy_nxt = (w_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd0   <= '0;
      r_rd1   <= '0;
      r_rdy0  <= 1'b0;
      r_rdy1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_en   <= w_en_nxt;
      r_rdy0 <= w_rdy0_nxt;
      r_rdy1 <= w_rdy1_nxt;
      r_busy <= w_busy_nxt;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_last  <= w_pick;
          r_cnt   <= 3'(RD_LAT);
          r_we    <= w_pick ? m1_we    : m0_we;
          r_addr  <= w_pick ? m1_addr  : m0_addr;
          r_wdata <= w_pick ? m1_wdata : m0_wdata;
        end
        S_ACCESS: begin
          r_cnt <= r_cnt - 3'd1;
          // write transactions leave both rdata registers untouched
          if (r_cnt == 3'd1 && !r_we) begin
            if (r_last) r_rd1 <= mem_rdata;
            else        r_rd0 <= mem_rdata;
          end
        end
        S_DONE:  r_we <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_en    = r_en;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign m0_rdata  = r_rd0;
  assign m1_rdata  = r_rd1;
  assign m0_ready  = r_rdy0;
  assign m1_ready  = r_rdy1;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter with a transaction-level model
// and a RAM model whose read data is only valid in its latency window.
module tb_mem_port_arbiter;
  localparam int RD_LAT = 3;
  localparam int AW     = 32;

  logic          clk, rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_port_arbiter #(.RD_LAT(RD_LAT), .AW(AW)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A1234;
  endfunction

  // RAM: data valid only RD_LAT-1 cycles after the mem_en cycle, garbage otherwise
  logic [3:0] ram_age;
  logic       ram_prev_en;
  int         viol = 0;
  wire  [3:0] w_age = mem_en ? 4'd0 : ram_age;
  assign mem_rdata = (w_age == 4'(RD_LAT-1)) ? ram_val(mem_addr) : 32'hBAD0BAD0;

  always_ff @(posedge clk) begin
    ram_prev_en <= mem_en;
    if (rst)         ram_age <= 4'hF;
    else if (mem_en) ram_age <= 4'd1;
    else if (ram_age != 4'hF) ram_age <= ram_age + 4'd1;
    if (!rst && mem_en && (ram_prev_en || !busy)) viol <= viol + 1;
  end

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Transaction model: m_left = cycles of this transaction still to come after the edge
  int          m_left = 0;
  logic        m_last = 1'b1, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wd = '0, m_rd0 = '0, m_rd1 = '0;

  task automatic model_edge();
    if (rst) begin
      m_left = 0; m_last = 1'b1; m_we = 1'b0;
      m_addr = '0; m_wd = '0; m_rd0 = '0; m_rd1 = '0;
    end else if (m_left == 0) begin
      if (m0_req || m1_req) begin
        m_last = (m0_req && m1_req) ? ~m_last : m1_req;
        m_we   = m_last ? m1_we    : m0_we;
        m_addr = m_last ? m1_addr  : m0_addr;
        m_wd   = m_last ? m1_wdata : m0_wdata;
        m_left = RD_LAT + 1;
      end
    end else begin
      m_left--;
      if (m_left == 1 && !m_we) begin
        if (m_last) m_rd1 = ram_val(m_addr);
        else        m_rd0 = ram_val(m_addr);
      end
      if (m_left == 0) m_we = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("busy",     32'(busy),     32'(m_left != 0));
    chk("mem_en",   32'(mem_en),   32'(m_left == RD_LAT + 1));
    chk("mem_we",   32'(mem_we),   32'(m_we));
    chk("mem_addr", mem_addr,      m_addr);
    chk("mem_wdata", mem_wdata,    m_wd);
    chk("m0_ready", 32'(m0_ready), 32'(m_left == 1 && !m_last));
    chk("m1_ready", 32'(m1_ready), 32'(m_left == 1 && m_last));
    chk("m0_rdata", m0_rdata,      m_rd0);
    chk("m1_rdata", m1_rdata,      m_rd1);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic wait_ready(input bit port, input int exp_lat, input string tag);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 20) begin
      step();
      n++;
      seen = port ? m1_ready : m0_ready;
    end
    chk(tag, seen ? n : 99, exp_lat);
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk("drain", 32'(busy), 32'd0);
  endtask

  int q_port[$];
  int q_cyc[$];

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    step(); step();
    rst = 1'b0;
    step();

    // m0 read of 0x10
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    wait_ready(0, RD_LAT + 1, "m0_read_lat");
    chk("m0_read_data", m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    step();

    // m1 write 0x20
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    step();
    chk("wr_en_we", {31'b0, mem_en & mem_we}, 32'd1);
    m1_req = 0;
    wait_ready(1, RD_LAT, "m1_write_lat");
    chk("wr_addr_hold", mem_addr, 32'h20);
    step();

    // continuous tie: alternate starting with m0
    m0_req = 1; m0_we = 0; m0_addr = 32'h44;
    m1_req = 1; m1_we = 0; m1_addr = 32'h88;
    for (int i = 0; i < 4 * (RD_LAT + 2) + 1; i++) begin
      step();
      if (m0_ready) begin q_port.push_back(0); q_cyc.push_back(cyc); end
      if (m1_ready) begin q_port.push_back(1); q_cyc.push_back(cyc); end
    end
    chk("rr_count", q_port.size(), 4);
    for (int i = 0; i < 4 && i < q_port.size(); i++) begin
      chk("rr_order", q_port[i], i % 2);
      if (i > 0) chk("rr_spacing", q_cyc[i] - q_cyc[i-1], RD_LAT + 2);
    end
    m0_req = 0; m1_req = 0;
    drain();
    step();

    // m0 drops its request right after grant
    m0_req = 1; m0_we = 0; m0_addr = 32'h14;
    step();
    m0_req = 0;
    wait_ready(0, RD_LAT, "drop_lat");
    step();

    // reset in first ACCESS cycle
    m1_req = 1; m1_we = 0; m1_addr = 32'h30;
    step();
    rst = 1'b1;
    step();
    chk("rst_addr", mem_addr, 32'd0);
    rst = 1'b0; m1_req = 0;
    step(); step();
    m0_req = 1; m0_addr = 32'h34; m1_req = 1; m1_addr = 32'h38;
    wait_ready(0, RD_LAT + 1, "post_rst_tie_m0");
    m0_req = 0;
    wait_ready(1, RD_LAT + 2, "post_rst_m1");
    m1_req = 0;
    step();

    // random traffic with occasional reset
    for (int i = 0; i < 1000; i++) begin
      if (!(m0_req && !m0_ready && $urandom_range(7) != 0)) begin
        m0_req = ($urandom_range(2) == 0); m0_we = 1'($urandom_range(1));
        m0_addr = {24'b0, 8'($urandom) & 8'hFC}; m0_wdata = $urandom;
      end
      if (!(m1_req && !m1_ready && $urandom_range(7) != 0)) begin
        m1_req = ($urandom_range(2) == 0); m1_we = 1'($urandom_range(1));
        m1_addr = {24'b0, 8'($urandom) & 8'hFC}; m1_wdata = $urandom;
      end
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 0; m0_req = 0; m1_req = 0;
    drain();
    step();
    chk("ram_viol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port m0_req, input, 1: CPU data-port request; held high until m0_ready.
REQ-006 Port m0_we, input, 1: CPU write enable; 1 = write, 0 = read.
REQ-007 Port m0_addr, input, AW: CPU address.
REQ-008 Port m0_wdata, input, 32: CPU write data.
REQ-009 Port m0_rdata, output, 32: CPU read data; valid only while m0_ready = 1.
REQ-010 Port m0_ready, output, 1: one-cycle completion pulse to the CPU; drives MIO_ready.
REQ-011 Ports m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready: same widths and meanings as m0_*, for the debug/loader requester.
REQ-012 Port mem_en, output, 1: RAM access strobe.
REQ-013 Port mem_we, output, 1: RAM write enable; qualified by mem_en.
REQ-014 Port mem_addr, output, AW: RAM address.
REQ-015 Port mem_wdata, output, 32: RAM write data.
REQ-016 Port mem_rdata, input, 32: RAM read data; valid RD_LAT cycles after mem_en.
REQ-017 Port busy, output, 1: high when the FSM is in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; state register and all outputs are registered.
REQ-019 IDLE with no request: stay in IDLE; mem_en = 0, mem_we = 0, both ready = 0.
REQ-020 IDLE with exactly one request: grant that requester.
REQ-021 IDLE with both requests: round-robin; grant the requester not granted last.
REQ-022 last_grant register updates on each grant; reset value = m1, so m0 wins the first tie.
REQ-023 On grant (IDLE to ACCESS), latch the winner's we, addr, and wdata into mem_we, mem_addr, and mem_wdata; these hold constant until DONE exits.
REQ-024 mem_en = 1 for exactly the first ACCESS cycle and 0 otherwise.
REQ-025 ACCESS loads a 3-bit counter with RD_LAT on entry and decrements each cycle; at count 1, transition to DONE.
REQ-026 Total ACCESS duration = RD_LAT cycles.
REQ-027 Capture mem_rdata into the granted port's rdata register on the last ACCESS cycle.
REQ-028 Latency: request sampled in IDLE at cycle t gives mem_en at t+1 and the granted ready = 1 at cycle t+1+RD_LAT.
REQ-029 In DONE, assert only the granted port's ready for one cycle, then return to IDLE.
REQ-030 The next arbitration happens in the IDLE cycle after DONE; minimum transaction spacing = RD_LAT + 2 cycles.
REQ-031 Writes follow identical timing to reads; rdata of the granted port on a write is don't-care, and the non-granted port's rdata holds its previous value.
REQ-032 If a request drops mid-transaction, the transaction still completes and ready still pulses; the arbiter never aborts a RAM access.
REQ-033 If the non-granted requester asserts mid-transaction, it waits; it is granted at the next IDLE under REQ-021.
REQ-034 m0_ready and m1_ready are never high in the same cycle.
REQ-035 mem_en is never high outside ACCESS.

Reset
REQ-036 rst = 1 at any edge forces: state = IDLE, counter = 0, last_grant = m1, mem_en = mem_we = 0, mem_addr = mem_wdata = 0, m0_rdata = m1_rdata = 0, m0_ready = m1_ready = 0, busy = 0.
REQ-037 Reset during ACCESS or DONE discards the transaction; no ready pulse follows reset release.
REQ-038 Arbitration resumes on the first cycle after rst deasserts.

Verification
REQ-039 RD_LAT = 1; m0 read addr 0x10, RAM returns 0xDEADBEEF -> mem_en at t+1, m0_ready with m0_rdata = 0xDEADBEEF at t+2, busy high for t+1..t+2.
REQ-040 RD_LAT = 3; m1 write addr 0x20, data 0x12345678 -> mem_en = 1, mem_we = 1 for one cycle, address and data held 4 cycles, m1_ready at t+4, m0_ready stays 0.
REQ-041 Both requests high continuously after reset -> grant order m0, m1, m0, m1; ready pulses every 3 cycles (RD_LAT = 1); never simultaneous.
REQ-042 m0 drops req in the cycle after grant -> mem_en still issued once; m0_ready still pulses at t+1+RD_LAT.
REQ-043 rst asserted in the first ACCESS cycle (RD_LAT = 3) -> next cycle all outputs reset; no ready pulse; a new m1 request after release is granted normally, with last_grant = m1 so a tie goes to m0.
REQ-044 A RAM model asserting if mem_en is high outside ACCESS or held more than one cycle -> zero violations across 1000 random request cycles.
